// File: rtl/conv_pkg.sv
// Shared types and widths for the convolution host sequencer.
package conv_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int Z_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_X    = 3'd1,
    ST_LOAD_Y    = 3'd2,
    ST_START     = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_RD_ADDR   = 3'd5,
    ST_RD_DATA   = 3'd6,
    ST_STREAM    = 3'd7
  } conv_seq_state_t;

  // Full convolution length; one extra bit so 31+31-1 cannot wrap.
  function automatic logic [ADDR_W:0] z_len(input logic [ADDR_W-1:0] size_x,
                                             input logic [ADDR_W-1:0] size_y);
    return {1'b0, size_x} + {1'b0, size_y} - {{ADDR_W{1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/conv_host_sequencer_if.sv
// Bus bundle between the host sequencer and its front end / convolution core.
interface conv_host_sequencer_if;
  import conv_pkg::*;

  logic              cfg_valid_i;
  logic              cfg_ready_o;
  logic [ADDR_W-1:0] cfg_size_x_i;
  logic [ADDR_W-1:0] cfg_size_y_i;
  logic              s_valid_i;
  logic              s_ready_o;
  logic [DATA_W-1:0] s_data_i;
  logic              mem_x_we_o;
  logic              mem_y_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              cp_start_o;
  logic [ADDR_W-1:0] cp_size_x_o;
  logic [ADDR_W-1:0] cp_size_y_o;
  logic              cp_busy_i;
  logic              cp_done_i;
  logic [ADDR_W:0]   z_addr_o;
  logic [Z_W-1:0]    z_data_i;
  logic              m_valid_o;
  logic              m_ready_i;
  logic [Z_W-1:0]    m_data_o;
  logic              m_last_o;
  logic              busy_o;
  logic              err_o;

  // master is the sequencer itself; slave is the surrounding system
  modport master (
    input  cfg_valid_i, cfg_size_x_i, cfg_size_y_i, s_valid_i, s_data_i,
           cp_busy_i, cp_done_i, z_data_i, m_ready_i,
    output cfg_ready_o, s_ready_o, mem_x_we_o, mem_y_we_o, mem_addr_o, mem_data_o,
           cp_start_o, cp_size_x_o, cp_size_y_o, z_addr_o, m_valid_o, m_data_o,
           m_last_o, busy_o, err_o
  );

  modport slave (
    output cfg_valid_i, cfg_size_x_i, cfg_size_y_i, s_valid_i, s_data_i,
           cp_busy_i, cp_done_i, z_data_i, m_ready_i,
    input  cfg_ready_o, s_ready_o, mem_x_we_o, mem_y_we_o, mem_addr_o, mem_data_o,
           cp_start_o, cp_size_x_o, cp_size_y_o, z_addr_o, m_valid_o, m_data_o,
           m_last_o, busy_o, err_o
  );

endinterface

// File: rtl/conv_seq_watchdog.sv
// Cycle counter that flags when the core has been waited on for TIMEOUT cycles.
module conv_seq_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (enable)
      cnt <= cnt + CNT_W'(1);
  end

  // Fires during the TIMEOUT-th enabled cycle so the FSM leaves on that edge
  assign timeout = enable && (cnt == LAST);

endmodule

// File: rtl/conv_host_sequencer.sv
// Host-side initiator: loads X/Y into the core, runs it, then streams Z out.
module conv_host_sequencer
  import conv_pkg::*;
#(
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rstn,
  conv_host_sequencer_if.master bus
);

  localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

  conv_seq_state_t   state, state_nx;
  logic [ADDR_W:0]   idx, idx_nx;
  logic [ADDR_W-1:0] size_x, size_y;
  logic [ADDR_W:0]   z_len_q;
  logic              cfg_ready_q, cp_start_q, busy_q, err_q;
  logic              m_valid_q, m_last_q;
  logic [Z_W-1:0]    m_data_q;
  logic              cfg_hs, size_zero, s_ready, s_hs, m_hs;
  logic              x_last, y_last, done_hit, wd_timeout;

  assign cfg_hs    = (state == ST_IDLE) && bus.cfg_valid_i && cfg_ready_q;
  assign size_zero = (bus.cfg_size_x_i == '0) || (bus.cfg_size_y_i == '0);
  assign s_ready   = (state == ST_LOAD_X) || (state == ST_LOAD_Y);
  assign s_hs      = s_ready && bus.s_valid_i;
  assign m_hs      = (state == ST_STREAM) && m_valid_q && bus.m_ready_i;
  assign x_last    = (idx == ({1'b0, size_x} - IDX_ONE));
  assign y_last    = (idx == ({1'b0, size_y} - IDX_ONE));
  assign done_hit  = (state == ST_WAIT_DONE) && bus.cp_done_i;

  conv_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (state != ST_WAIT_DONE),
    .enable  (state == ST_WAIT_DONE),
    .timeout (wd_timeout)
  );

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      ST_IDLE: begin
        if (cfg_hs && !size_zero) begin
          state_nx = ST_LOAD_X;
          idx_nx   = '0;
        end
      end
      ST_LOAD_X: begin
        if (s_hs) begin
          if (x_last) begin
            state_nx = ST_LOAD_Y;
            idx_nx   = '0;
          end else begin
            idx_nx = idx + IDX_ONE;
          end
        end
      end
      ST_LOAD_Y: begin
        if (s_hs) begin
          if (y_last) begin
            state_nx = ST_START;
            idx_nx   = '0;
          end else begin
            idx_nx = idx + IDX_ONE;
          end
        end
      end
      ST_START: state_nx = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        // A done pulse wins over a timeout landing on the same cycle
        if (bus.cp_done_i) begin
          state_nx = ST_RD_ADDR;
          idx_nx   = '0;
        end else if (wd_timeout) begin
          state_nx = ST_IDLE;
        end
      end
      ST_RD_ADDR: state_nx = ST_RD_DATA;
      ST_RD_DATA: state_nx = ST_STREAM;
      ST_STREAM: begin
        if (m_hs) begin
          if (m_last_q) begin
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_RD_ADDR;
            idx_nx   = idx + IDX_ONE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      idx     <= '0;
      size_x  <= '0;
      size_y  <= '0;
      z_len_q <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      if (cfg_hs && !size_zero) begin
        size_x <= bus.cfg_size_x_i;
        size_y <= bus.cfg_size_y_i;
      end
      if (done_hit)
        z_len_q <= z_len(size_x, size_y);
    end
  end

  // Status outputs are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cfg_ready_q <= 1'b0;
      cp_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
    end else begin
      cfg_ready_q <= (state_nx == ST_IDLE);
      cp_start_q  <= (state_nx == ST_START) || (state_nx == ST_WAIT_DONE);
      busy_q      <= (state_nx != ST_IDLE);
      err_q       <= (cfg_hs && size_zero) ||
                     ((state == ST_WAIT_DONE) && !bus.cp_done_i && wd_timeout);
      if (state == ST_RD_DATA) begin
        m_valid_q <= 1'b1;
        m_data_q  <= bus.z_data_i;
        m_last_q  <= (idx == (z_len_q - IDX_ONE));
      end else if (m_hs) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end
    end
  end

  assign bus.cfg_ready_o = cfg_ready_q;
  assign bus.s_ready_o   = s_ready;
  assign bus.mem_x_we_o  = s_hs && (state == ST_LOAD_X);
  assign bus.mem_y_we_o  = s_hs && (state == ST_LOAD_Y);
  assign bus.mem_addr_o  = idx[ADDR_W-1:0];
  assign bus.mem_data_o  = bus.s_data_i;
  assign bus.cp_start_o  = cp_start_q;
  assign bus.cp_size_x_o = size_x;
  assign bus.cp_size_y_o = size_y;
  assign bus.z_addr_o    = idx;
  assign bus.m_valid_o   = m_valid_q;
  assign bus.m_data_o    = m_data_q;
  assign bus.m_last_o    = m_last_q;
  assign bus.busy_o      = busy_q;
  assign bus.err_o       = err_q;

endmodule

// File: doc/conv_host_sequencer.md
# conv_host_sequencer

Host-side initiator for the convolution processor core. Accepts a job descriptor (X and Y lengths), streams X then Y samples into the core's input memories, and drives the core's start/busy/done handshake. After completion it reads the result memory Z and emits Z over a valid/ready stream. It sits between the bus/stream front end and the convolution core, and is the only driver of the core's start input.

## Interface
- DATA_W, 8: X/Y sample width
- ADDR_W, 5: X/Y memory address width; max length 2^ADDR_W − 1
- Z_W, 16: result sample width
- TIMEOUT, 4096: maximum cycles in WAIT_DONE before abort

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- cfg_valid_i / cfg_ready_o  in/out  1  job descriptor handshake
- cfg_size_x_i, cfg_size_y_i  in  ADDR_W  X and Y lengths
- s_valid_i / s_ready_o  in/out  1  sample input handshake
- s_data_i  in  DATA_W  sample; X samples first, then Y samples
- mem_x_we_o, mem_y_we_o  out  1  write enables for the X and Y memories
- mem_addr_o  out  ADDR_W  X/Y write address
- mem_data_o  out  DATA_W  X/Y write data
- cp_start_o  out  1  core start; level signal
- cp_size_x_o, cp_size_y_o  out  ADDR_W  latched lengths driven to the core
- cp_busy_i, cp_done_i  in  1  core status; done is a 1-cycle pulse
- z_addr_o  out  ADDR_W+1  Z read address
- z_data_i  in  Z_W  Z read data, 1-cycle read latency
- m_valid_o / m_ready_i  out/in  1  result output handshake
- m_data_o  out  Z_W  result sample
- m_last_o  out  1  marks the final Z sample
- busy_o  out  1  high in every state except IDLE
- err_o  out  1  1-cycle pulse on a rejected descriptor or a timeout

## Operation
- FSM states: IDLE, LOAD_X, LOAD_Y, START, WAIT_DONE, RD_ADDR, RD_DATA, STREAM.
- IDLE
  - cfg_ready_o=1.
  - On a cfg handshake with both sizes nonzero: latch the sizes, clear the index, go to LOAD_X.
  - If either size is 0: pulse err_o, stay in IDLE.
- LOAD_X
  - s_ready_o=1. Each s handshake writes: mem_x_we_o=1, mem_addr_o=index, mem_data_o=s_data_i, then index++.
  - After sample size_x−1: index=0, go to LOAD_Y.
- LOAD_Y: same as LOAD_X but uses mem_y_we_o. After sample size_y−1, go to START.
- START: cp_start_o=1, go to WAIT_DONE.
- WAIT_DONE
  - cp_start_o stays 1 until cp_done_i is sampled high.
  - On cp_done_i: deassert start, set z_len = size_x + size_y − 1 (ADDR_W+1 bits, no overflow), index=0, go to RD_ADDR.
  - The core must see start low after done before it re-arms.
  - The watchdog counts WAIT_DONE cycles. At TIMEOUT: start=0, pulse err_o, go to IDLE.
- RD_ADDR: drive z_addr_o=index, go to RD_DATA.
- RD_DATA: capture z_data_i into m_data_o, set m_valid_o=1, set m_last_o=(index==z_len−1), go to STREAM.
- STREAM
  - m_valid_o and m_data_o are held stable until m_ready_i.
  - On handshake: if last, go to IDLE; otherwise index++ and go to RD_ADDR.
- cp_busy_i is informational only. If cp_done_i arrives outside WAIT_DONE, it is ignored.
- Outputs are registered: m_*, cp_start_o, busy_o, err_o. Memory write strobes are combinational from the s handshake.

## Timing
- Reset values: all outputs 0, index 0, watchdog 0. State=IDLE, so cfg_ready_o=1 one cycle after rstn is released.
- Asserting rstn mid-job aborts immediately: start drops, memory contents are left undefined, no err_o.
- Load phase accepts 1 sample/cycle. X-to-Y boundary has no bubble.
- cp_start_o rises 1 cycle after the final Y write.
- cp_done_i → first m_valid_o: 3 cycles (WAIT_DONE→RD_ADDR→RD_DATA→STREAM).
- Output throughput: 1 sample per 3 cycles with m_ready_i tied high.
- m_valid_o must never drop without a handshake.
- m_last_o is asserted only together with m_valid_o.
- busy_o falls the cycle after the last handshake.
- In IDLE, s_ready_o=0; samples are not consumed.

## Structure
- Shared package conv_pkg holds:
  - state enum conv_seq_state_t (logic [2:0])
  - DATA_W, ADDR_W, Z_W defaults
  - function z_len(size_x, size_y)
- One sub-module: conv_seq_watchdog (cycle counter with clear, enable and timeout flag, parameter TIMEOUT).
- Remainder is a single FSM with datapath registers.

## Test plan
- **Nominal job**: sizes 3/2, X={1,2,3}, Y={1,1}, core model with done after 20 cycles → 3 X writes at addr 0..2, 2 Y writes at addr 0..1, start high until done, then 4 Z samples {1,3,5,3} with m_last on the 4th.
- **Zero size**: cfg size_x=0 → err_o pulse, stays IDLE, no memory writes.
- **Backpressure**: m_ready_i toggles 1/0 every cycle → m_data stable while stalled, all 4 samples delivered in order, no duplicates.
- **Timeout**: core never asserts done, TIMEOUT=64 → start falls and err_o pulses at cycle 64 of WAIT_DONE, back to IDLE, next job succeeds.
- **Sparse input**: s_valid with gaps during LOAD → addresses stay contiguous, no write without a handshake.
- **Mid-job reset**: rstn asserted during WAIT_DONE → all outputs 0, cfg_ready_o=1 after release.
